key_uart_tx: RTL and testbench
==============================

KEY_UART_TX -- requirements
Module: key_uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, sys_clk frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate.
REQ-003 Parameter PRESS_CODE, default 8'h50 ('P'), byte sent on a press event.
REQ-004 Parameter RELEASE_CODE, default 8'h52 ('R'), byte sent on a release event.
REQ-005 sys_clk  input  1  clock; all logic on rising edge.
REQ-006 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key_pulse  input  1  one-cycle event strobe from the debounce filter, synchronous to sys_clk; events alternate press, release, press, ..., starting with press.
REQ-008 uart_txd  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-009 tx_busy  output  1  high while a frame is on the line or a byte is queued.
REQ-010 key_state  output  1  tracked key level: 0 released, 1 pressed.
REQ-011 overflow  output  1  one-cycle pulse when an event byte is dropped.

Function
REQ-012 BIT_CYC SHALL equal CLK_FREQ/BAUD, integer division (434 at the defaults); each bit SHALL last exactly BIT_CYC cycles and each frame exactly 10*BIT_CYC cycles.
REQ-013 The key_pulse sample in the first clock cycle after reset deassertion SHALL be ignored, because the debounce filter holds its output high through reset.
REQ-014 Every other cycle with key_pulse=1 SHALL be an accepted event: key_state toggles on the same edge.
REQ-015 Byte selection: key_state 0->1 enqueues PRESS_CODE; key_state 1->0 enqueues RELEASE_CODE.
REQ-016 Event bytes SHALL be buffered in a 2-entry FIFO, written on the edge that samples the event.
REQ-017 Transmit FSM states: IDLE, START, DATA, STOP.
REQ-018 IDLE: uart_txd=1; if the FIFO is non-empty, pop the head into the shift register, clear the bit counter, go to START.
REQ-019 START: uart_txd=0 for BIT_CYC cycles, then go to DATA with bit index 0.
REQ-020 DATA: uart_txd = shift[index] for BIT_CYC cycles per bit, index 0..7; after bit 7 go to STOP.
REQ-021 STOP: uart_txd=1 for BIT_CYC cycles, then go to IDLE; a queued byte starts its START bit on the cycle after STOP ends, with no extra idle bit.
REQ-022 uart_txd SHALL be driven from a register (glitch-free); the line falls on the second rising edge after the edge that samples an accepted key_pulse when the FSM is IDLE and the FIFO is empty.
REQ-023 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-024 A push to a full FIFO with no simultaneous pop: the byte is dropped, key_state still toggles, overflow=1 for exactly that cycle.
REQ-025 tx_busy SHALL be 1 whenever the FSM is not IDLE or the FIFO is non-empty, and 0 otherwise.
REQ-026 The baud counter SHALL count 0..BIT_CYC-1 and wrap; it is held at 0 in IDLE.
REQ-027 Any reset assertion, including mid-frame, SHALL abort the frame immediately, flush the FIFO, and return uart_txd high asynchronously.

Reset
REQ-028 Under reset: uart_txd=1, tx_busy=0, key_state=0, overflow=0, FSM=IDLE, FIFO empty, all counters 0.
REQ-029 The post-reset ignore window of REQ-013 SHALL be re-armed by every reset assertion.

Verification
V-1 Reset release with key_pulse held high for the first cycle -> key_state stays 0, no frame, tx_busy stays 0.
V-2 Single key_pulse -> key_state=1; 8N1 frame of 0x50 decoded at 434 cycles/bit; line low at edge N+2; tx_busy falls after 4340 cycles.
V-3 Two pulses 10 cycles apart -> frames 0x50 then 0x52 back-to-back (stop bit immediately followed by start bit); key_state ends at 0.
V-4 Four pulses within one frame time -> 0x50 transmitted, 0x52 and 0x50 queued, 4th event (0x52) dropped with overflow pulsing once; key_state ends at 0.
V-5 Reset asserted mid DATA bit 3 -> uart_txd=1 immediately, FIFO empty, key_state=0; a subsequent pulse yields a clean 0x50 frame.
V-6 Push on the same cycle as a pop while the FIFO is full -> no overflow, byte order preserved.

Source files
------------

// File: rtl/key_uart_tx_if.sv
// Key-event / UART-line bundle between the key_uart_tx block and its surroundings.
// master drives the key strobe and watches the line; slave is the transmitter.
interface key_uart_tx_if;
  logic key_pulse;
  logic uart_txd;
  logic tx_busy;
  logic key_state;
  logic overflow;

  modport master (output key_pulse, input uart_txd, tx_busy, key_state, overflow);
  modport slave  (input key_pulse, output uart_txd, tx_busy, key_state, overflow);
endinterface

// File: rtl/key_uart_tx.sv
// Key press/release events turned into 8N1 UART bytes through a 2-entry FIFO.
// uart_txd is registered and lags the FSM state by one cycle.
module key_uart_tx #(
  parameter int          CLK_FREQ     = 50_000_000,
  parameter int          BAUD         = 115200,
  parameter logic [7:0]  PRESS_CODE   = 8'h50,
  parameter logic [7:0]  RELEASE_CODE = 8'h52
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  key_uart_tx_if.slave bus
);
  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          ign_q, ks_q, ovf_q;
  logic [7:0]    mem_q [2];
  logic          wp_q, rp_q;
  logic [1:0]    cnt_q;
  logic          tick, fifo_ne, acc, pop, push, drop;

  assign tick    = (baud_q == LAST);
  assign fifo_ne = (cnt_q != 2'd0);
  // The debounce filter holds key_pulse high through reset; drop its first sample.
  assign acc     = bus.key_pulse & ~ign_q;
  assign push    = acc & ((cnt_q != 2'd2) | pop);
  assign drop    = acc & ~push;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fifo_ne) state_d = START;
      START:   if (tick) state_d = DATA;
      DATA:    if (tick && bit_q == 3'd7) state_d = STOP;
      STOP:    if (tick) state_d = fifo_ne ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A queued byte is popped on the last STOP cycle so frames abut with no idle gap.
  always_comb begin
    pop   = 1'b0;
    txd_d = 1'b1;
    case (state_q)
      IDLE:    pop   = fifo_ne;
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[bit_q];
      STOP:    pop   = tick & fifo_ne;
      default: ;
    endcase
  end

  always_comb begin
    baud_d  = (state_q == IDLE || tick) ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    if (pop) begin
      bit_d   = 3'd0;
      shift_d = mem_q[rp_q];
    end else if (state_q == DATA && tick) begin
      bit_d   = bit_q + 3'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      txd_q   <= 1'b1;
      ign_q   <= 1'b1;
      ks_q    <= 1'b0;
      ovf_q   <= 1'b0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ign_q   <= 1'b0;
      ovf_q   <= drop;
      if (acc)  ks_q <= ~ks_q;
      if (push) wp_q <= ~wp_q;
      if (pop)  rp_q <= ~rp_q;
      cnt_q   <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // When full with a simultaneous pop, wp==rp: the old head is read before this write lands.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wp_q] <= ks_q ? RELEASE_CODE : PRESS_CODE;
  end

  assign bus.uart_txd  = txd_q;
  assign bus.tx_busy   = (state_q != IDLE) | fifo_ne;
  assign bus.key_state = ks_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_key_uart_tx.sv
// Bench for key_uart_tx: per-cycle check against a transaction-level model,
// an independent line decoder, a vector table and hand-written corner sequences.
module tb_key_uart_tx;
  localparam int B = 50_000_000 / 115200;
  localparam int F = 10 * B;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  key_uart_tx_if bus();

  key_uart_tx dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: bytes queue, each pop owns the line for F cycles starting one cycle later.
  logic [7:0] q_m[$];
  int   k, ek, next_free, cur_t;
  logic [7:0] cur_b;
  bit   have_cur, ign, ks, ovf, m_rst;

  function automatic void m_reset();
    q_m.delete();
    k = 0; ek = 0; next_free = 0; have_cur = 0;
    ign = 1; ks = 0; ovf = 0; m_rst = 1;
  endfunction

  function automatic void m_step();
    bit acc;
    logic [7:0] b;
    acc = bus.key_pulse && !ign;
    ign = 0; ovf = 0; m_rst = 0;
    if (q_m.size() > 0 && k >= next_free) begin
      cur_b = q_m.pop_front();
      cur_t = k;
      have_cur = 1;
      next_free = k + F;
    end
    if (acc) begin
      b  = ks ? 8'h52 : 8'h50;
      ks = !ks;
      if (q_m.size() < 2) q_m.push_back(b);
      else ovf = 1;
    end
    ek = k;
    k++;
  endfunction

  function automatic logic [3:0] m_expect();
    logic txd;
    int off, idx;
    if (m_rst) return 4'b1000;
    txd = 1'b1;
    if (have_cur && ek > cur_t) begin
      off = ek - 1 - cur_t;
      if (off < F) begin
        idx = off / B;
        if (idx == 0)      txd = 1'b0;
        else if (idx <= 8) txd = cur_b[idx-1];
      end
    end
    return {txd, (q_m.size() > 0) || (ek < next_free), ks, ovf};
  endfunction

  // Line decoder, independent of the model: mid-bit sampling from the falling edge.
  int   cyc = 0;
  bit   d_on = 0, d_ok;
  int   d_t, rel;
  logic [7:0] d_b;
  int   dec[$];
  int   starts[$];
  int   ovf_cnt = 0;

  always begin
    logic [3:0] ev, av;
    @(posedge sys_clk);
    cyc++;
    if (!sys_rst_n) m_reset();
    else m_step();
    #1;
    ev = m_expect();
    av = {bus.uart_txd, bus.tx_busy, bus.key_state, bus.overflow};
    chk("cycle {txd,busy,key_state,overflow}", int'(av), int'(ev));
    if (bus.overflow) ovf_cnt++;
    if (!sys_rst_n) d_on = 0;
    else if (!d_on) begin
      if (bus.uart_txd == 1'b0) begin
        d_on = 1; d_t = cyc; starts.push_back(cyc);
      end
    end else begin
      rel = cyc - d_t;
      if (rel == B/2) d_ok = (bus.uart_txd == 1'b0);
      for (int i = 0; i < 8; i++)
        if (rel == B/2 + (i+1)*B) d_b[i] = bus.uart_txd;
      if (rel == B/2 + 9*B) dec.push_back((d_ok && bus.uart_txd) ? int'(d_b) : 256 + int'(d_b));
      if (rel == F-1) d_on = 0;
    end
  end

  typedef struct {
    int              n;
    logic [2:0][15:0] gap;
    int              nexp;
    logic [3:0][7:0] exp;
    logic            ks;
    int              novf;
  } vec_t;

  vec_t tbl[4];

  task automatic clear_obs();
    dec.delete(); starts.delete(); ovf_cnt = 0;
  endtask

  // Holds key_pulse high through reset and the first cycle after release.
  task automatic do_reset();
    bus.key_pulse = 1'b1;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("reset uart_txd", int'(bus.uart_txd), 1);
    chk("reset tx_busy", int'(bus.tx_busy), 0);
    chk("reset key_state", int'(bus.key_state), 0);
    chk("reset overflow", int'(bus.overflow), 0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    bus.key_pulse = 1'b0;
    clear_obs();
  endtask

  task automatic send(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      bus.key_pulse = 1'b1;
      @(negedge sys_clk);
      bus.key_pulse = 1'b0;
      if (i < v.n - 1) repeat (int'(v.gap[i]) - 1) @(negedge sys_clk);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.tx_busy && n < 8*F) begin
      @(negedge sys_clk);
      n++;
    end
    chk("tx_busy falls within bound", int'(n < 8*F), 1);
    repeat (5) @(negedge sys_clk);
  endtask

  initial begin
    #1_900_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    bus.key_pulse = 1'b0;
    tbl[0] = '{1, '0, 1, {8'h00, 8'h00, 8'h00, 8'h50}, 1'b1, 0};
    tbl[1] = '{2, {16'd0, 16'd0, 16'd10}, 2, {8'h00, 8'h00, 8'h52, 8'h50}, 1'b0, 0};
    tbl[2] = '{4, {16'd10, 16'd10, 16'd10}, 3, {8'h00, 8'h50, 8'h52, 8'h50}, 1'b0, 1};
    // Fourth pulse lands on the edge that pops the second byte while the FIFO is full.
    tbl[3] = '{4, {16'(F-1), 16'd1, 16'd1}, 4, {8'h52, 8'h50, 8'h52, 8'h50}, 1'b0, 0};

    // Reset release with key_pulse still high: ignored.
    do_reset();
    repeat (20) @(negedge sys_clk);
    chk("v1 key_state", int'(bus.key_state), 0);
    chk("v1 tx_busy", int'(bus.tx_busy), 0);
    chk("v1 no frame", starts.size(), 0);

    for (int t = 0; t < 4; t++) begin
      do_reset();
      repeat (5) @(negedge sys_clk);
      send(tbl[t]);
      wait_idle();
      chk($sformatf("vec%0d frame count", t), dec.size(), tbl[t].nexp);
      for (int i = 0; i < tbl[t].nexp; i++)
        chk($sformatf("vec%0d byte%0d", t, i), (i < dec.size()) ? dec[i] : -1, int'(tbl[t].exp[i]));
      chk($sformatf("vec%0d key_state", t), int'(bus.key_state), int'(tbl[t].ks));
      chk($sformatf("vec%0d overflow pulses", t), ovf_cnt, tbl[t].novf);
      for (int i = 1; i < starts.size(); i++)
        chk($sformatf("vec%0d start spacing", t), starts[i] - starts[i-1], F);
    end

    // Reset in the middle of data bit 3 with a second byte queued.
    do_reset();
    repeat (5) @(negedge sys_clk);
    send(tbl[1]);
    repeat (4*B + 190) @(negedge sys_clk);
    chk("v5 line in bit3 before reset", int'(bus.uart_txd), 0);
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("v5 async uart_txd", int'(bus.uart_txd), 1);
    chk("v5 async tx_busy", int'(bus.tx_busy), 0);
    chk("v5 async key_state", int'(bus.key_state), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    clear_obs();
    repeat (5) @(negedge sys_clk);
    send(tbl[0]);
    wait_idle();
    chk("v5 frame count after reset", dec.size(), 1);
    chk("v5 byte after reset", (dec.size() > 0) ? dec[0] : -1, 8'h50);
    chk("v5 key_state", int'(bus.key_state), 1);

    // Random pulse spacing; the per-cycle model check does the work.
    do_reset();
    for (int c = 0; c < 12000; ) begin
      int g;
      g = int'($urandom_range(1, 2500));
      bus.key_pulse = 1'b1;
      @(negedge sys_clk);
      bus.key_pulse = 1'b0;
      repeat (g - 1) @(negedge sys_clk);
      c += g;
    end
    wait_idle();
    for (int i = 0; i < dec.size(); i++)
      chk("random frame byte valid", int'(dec[i] == 8'h50 || dec[i] == 8'h52), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
